// File: rtl/pipe_pkg.sv
// Shared definitions for inter-stage pipeline registers: control-bus widths,
// the NOP control word and the occupancy / skid-FSM state encodings.
package pipe_pkg;

  // Control bus slices; stage instances concatenate them as {ie, mem, wb}.
  localparam int IE_CTRL_W  = 6;
  localparam int MEM_CTRL_W = 5;
  localparam int WB_CTRL_W  = 5;
  localparam int CTRL_W_DEF = IE_CTRL_W + MEM_CTRL_W + WB_CTRL_W;
  localparam int DATA_W_DEF = 64;

  // All-zero control word seen downstream as a bubble.
  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = 16'h0000;

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_stage_perf.sv
// Saturating performance counters for one pipeline stage: cycles a valid
// entry is held without leaving, and flushes that squash live entries.
// Only instantiated when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_perf #(
  parameter int CNT_W = 32
) (
  input  logic             p_clk,
  input  logic             p_reset,
  input  logic             stall_evt_s,
  input  logic             flush_evt_s,
  output logic [CNT_W-1:0] p_stall_cycles,
  output logic [CNT_W-1:0] p_flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Stall-cycle counter, saturating at all-ones.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_evt_s && (stall_cnt_r != CNT_MAX_C)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE_C;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Effective-flush counter, saturating at all-ones.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (flush_evt_s && (flush_cnt_r != CNT_MAX_C)) begin
      flush_cnt_r <= flush_cnt_r + CNT_ONE_C;
    end else begin
      flush_cnt_r <= flush_cnt_r;
    end
  end

  assign p_stall_cycles = stall_cnt_r;
  assign p_flush_count  = flush_cnt_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// stall, flush and bubble insertion. SKID=1 adds a one-entry skid slot so
// p_in_ready comes from a register instead of the downstream ready.
// Optional macro PIPE_STAGE_PERF_EN adds p_stall_cycles / p_flush_count.
//
// Both SKID settings share one occupancy FSM: with SKID=0 the ready equation
// guarantees that an accept in MAIN always coincides with a departure, so
// FULL is unreachable and the skid slot is never loaded.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 0,
  parameter int CNT_W  = 32
) (
  input  logic              p_clk,
  input  logic              p_reset,
  input  logic              p_in_valid,
  output logic              p_in_ready,
  input  logic [DATA_W-1:0] p_in_data,
  input  logic [CTRL_W-1:0] p_in_ctrl,
  output logic              p_out_valid,
  input  logic              p_out_ready,
  output logic [DATA_W-1:0] p_out_data,
  output logic [CTRL_W-1:0] p_out_ctrl,
  input  logic              p_stall,
  input  logic              p_flush,
  output logic [1:0]        p_occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  p_stall_cycles,
  output logic [CNT_W-1:0]  p_flush_count
`endif
);

  localparam logic [CTRL_W-1:0] CTRL_ZERO_C = CTRL_W'(CTRL_NOP);

  occ_e              state_r;
  occ_e              state_nxt_s;
  logic              out_valid_r;
  logic [DATA_W-1:0] main_data_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] skid_data_r;
  logic [CTRL_W-1:0] skid_ctrl_r;

  logic in_ready_s;
  logic in_acc_s;
  logic out_acc_s;
  logic load_main_s;
  logic load_skid_s;
  logic move_skid_s;
  logic clear_main_s;

  assign out_acc_s = out_valid_r & p_out_ready & ~p_stall;
  assign in_acc_s  = p_in_valid & in_ready_s;

  generate
    if (SKID == 0) begin : g_comb_ready
      // Accept when not stalled and the main register is free or draining.
      always_comb begin
        in_ready_s = ~p_stall & (~out_valid_r | p_out_ready);
      end
    end else begin : g_skid_ready
      logic in_ready_r;

      // Registered ready: drops one cycle after the skid slot fills.
      always_ff @(posedge p_clk) begin
        if (p_reset) begin
          in_ready_r <= 1'b1;
        end else begin
          in_ready_r <= (state_nxt_s != OCC_FULL);
        end
      end

      // Reset gating keeps ready low for the whole reset cycle.
      assign in_ready_s = in_ready_r & ~p_reset;
    end
  endgenerate

  // Occupancy state register.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      state_r <= OCC_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: flush empties the stage, otherwise track accepts/departures.
  always_comb begin
    state_nxt_s = state_r;
    if (p_flush) begin
      state_nxt_s = OCC_EMPTY;
    end else begin
      case (state_r)
        OCC_EMPTY: state_nxt_s = in_acc_s ? OCC_MAIN : OCC_EMPTY;
        OCC_MAIN: begin
          if (in_acc_s && !out_acc_s) begin
            state_nxt_s = OCC_FULL;
          end else if (!in_acc_s && out_acc_s) begin
            state_nxt_s = OCC_EMPTY;
          end else begin
            state_nxt_s = OCC_MAIN;
          end
        end
        OCC_FULL:  state_nxt_s = out_acc_s ? OCC_MAIN : OCC_FULL;
        default:   state_nxt_s = OCC_EMPTY;
      endcase
    end
  end

  // Datapath actions decoded from state and handshakes.
  always_comb begin
    load_main_s  = 1'b0;
    load_skid_s  = 1'b0;
    move_skid_s  = 1'b0;
    clear_main_s = 1'b0;
    if (p_flush) begin
      clear_main_s = 1'b1;
    end else begin
      case (state_r)
        OCC_EMPTY: load_main_s = in_acc_s;
        OCC_MAIN: begin
          if (in_acc_s && out_acc_s) begin
            load_main_s = 1'b1;
          end else if (in_acc_s) begin
            load_skid_s = 1'b1;
          end else if (out_acc_s) begin
            clear_main_s = 1'b1;
          end else begin
            load_main_s = 1'b0;
          end
        end
        OCC_FULL:  move_skid_s = out_acc_s;
        default:   clear_main_s = 1'b1;
      endcase
    end
  end

  // Output valid mirrors the next occupancy so it is a plain flop.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (state_nxt_s != OCC_EMPTY);
    end
  end

  // Main register: data holds on bubbles, ctrl is zeroed so bubbles read NOP.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      main_data_r <= {DATA_W{1'b0}};
      main_ctrl_r <= CTRL_ZERO_C;
    end else if (load_main_s) begin
      main_data_r <= p_in_data;
      main_ctrl_r <= p_in_ctrl;
    end else if (move_skid_s) begin
      main_data_r <= skid_data_r;
      main_ctrl_r <= skid_ctrl_r;
    end else if (clear_main_s) begin
      main_data_r <= main_data_r;
      main_ctrl_r <= CTRL_ZERO_C;
    end else begin
      main_data_r <= main_data_r;
      main_ctrl_r <= main_ctrl_r;
    end
  end

  // Skid slot payload; validity is the FULL state.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      skid_data_r <= {DATA_W{1'b0}};
      skid_ctrl_r <= CTRL_ZERO_C;
    end else if (load_skid_s) begin
      skid_data_r <= p_in_data;
      skid_ctrl_r <= p_in_ctrl;
    end else begin
      skid_data_r <= skid_data_r;
      skid_ctrl_r <= skid_ctrl_r;
    end
  end

  assign p_in_ready  = in_ready_s;
  assign p_out_valid = out_valid_r;
  assign p_out_data  = main_data_r;
  assign p_out_ctrl  = main_ctrl_r;
  assign p_occupancy = state_r;

`ifdef PIPE_STAGE_PERF_EN
  logic stall_evt_s;
  logic flush_evt_s;

  assign stall_evt_s = out_valid_r & ~out_acc_s;
  assign flush_evt_s = p_flush & (state_r != OCC_EMPTY);

  pipe_stage_perf #(
    .CNT_W (CNT_W)
  ) u_perf (
    .p_clk          (p_clk),
    .p_reset        (p_reset),
    .stall_evt_s    (stall_evt_s),
    .flush_evt_s    (flush_evt_s),
    .p_stall_cycles (p_stall_cycles),
    .p_flush_count  (p_flush_count)
  );
`endif

endmodule
